// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch/data request ports, memory port and debug grant of the arbiter
interface mem_bus_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic [1:0]  grant;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, d_rdata, d_ready, err, m_req, m_we, m_wstrb, m_addr, m_wdata, grant
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, err, m_req, m_we, m_wstrb, m_addr, m_wdata, grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: fetch/data arbiter for a single-port memory with anti-starvation and timeout
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic [7:0]  tmo_cnt;
  logic        fetch_win;
  logic        tmo_hit;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // arbitration decision, timeout detection and next state
  always_comb begin
    fetch_win = bus.i_req && (!bus.d_req || starve_cnt >= STARVE_MAX);
    tmo_hit   = !bus.m_ack && tmo_cnt == TMO_LAST;
    state_nxt = state == IDLE  ? ((bus.i_req || bus.d_req) ? ISSUE : IDLE) :
                state == ISSUE ? ((bus.m_ack || tmo_hit) ? RESP : ISSUE) : IDLE;
  end
  // latch the winner, run the memory handshake and produce the one-cycle response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_wstrb <= 4'h0;
      bus.m_addr  <= 32'h0;
      bus.m_wdata <= 32'h0;
      bus.i_rdata <= 32'h0;
      bus.d_rdata <= 32'h0;
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.err     <= 1'b0;
      bus.grant   <= 2'b00;
      starve_cnt  <= 4'h0;
      tmo_cnt     <= 8'h0;
    end else if (state == IDLE && state_nxt == ISSUE) begin
      bus.grant   <= fetch_win ? 2'b01 : 2'b10;
      bus.m_req   <= 1'b1;
      bus.m_we    <= !fetch_win && bus.d_we;
      bus.m_wstrb <= fetch_win ? 4'h0 : bus.d_wstrb;
      bus.m_addr  <= fetch_win ? bus.i_addr : bus.d_addr;
      bus.m_wdata <= fetch_win ? 32'h0 : bus.d_wdata;
      tmo_cnt     <= 8'h0;
      starve_cnt  <= (fetch_win || !bus.i_req) ? 4'h0 :
                     starve_cnt == 4'hF ? starve_cnt : starve_cnt + 4'h1;
    end else if (state == ISSUE) begin
      tmo_cnt <= tmo_cnt + 8'h1;
      if (state_nxt == RESP) begin
        bus.m_req   <= 1'b0;
        bus.i_ready <= bus.grant[0];
        bus.d_ready <= bus.grant[1];
        bus.err     <= tmo_hit;
        if (bus.grant[0]) bus.i_rdata <= tmo_hit ? 32'h0 : bus.m_rdata;
        if (bus.grant[1] && (tmo_hit || !bus.m_we)) bus.d_rdata <= tmo_hit ? 32'h0 : bus.m_rdata;
      end
    end else if (state == RESP) begin
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.err     <= 1'b0;
      bus.grant   <= 2'b00;
    end
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shared-memory arbiter for the RISC-V SoC. It sits between the CPU core's instruction-fetch port and data load/store port and the single-port unified memory. Each cycle it decides which requester owns the memory and sequences one transaction at a time through an issue/acknowledge handshake. Data accesses have priority, bounded by a fetch anti-starvation counter, and a timeout guards against a memory that never acknowledges.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced (1..15)
- TIMEOUT, 255: ISSUE cycles without m_ack before the transaction is aborted (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetch data, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with d_* stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_wstrb  in  4  store byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- err  out  1  pulses with i_ready/d_ready when the transaction timed out
- m_req  out  1  memory request, held until m_ack or timeout
- m_we  out  1  memory write enable
- m_wstrb  out  4  memory byte enables
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, sampled when m_ack=1
- m_ack  in  1  memory acknowledge, single cycle
- grant  out  2  debug: 00 idle, 01 fetch owns, 10 data owns

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if either req is high, arbitrate, latch the winner's request into the m_* registers, and go to ISSUE. Otherwise stay.
- Arbitration: a single requester wins. With both requesting, data wins unless starve_cnt ≥ STARVE_LIMIT, in which case fetch wins.
- starve_cnt (4 bits): +1 on a data grant while i_req=1. Cleared on any fetch grant, or on a data grant with i_req=0. Saturates at 15.
- Fetch transactions drive m_we=0, m_wstrb=0, m_wdata=0.
- ISSUE: m_req=1 with stable m_* outputs. tmo_cnt (8 bits) counts up from 0.
  - m_ack=1: capture m_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
  - tmo_cnt reaches TIMEOUT-1 without ack: drop m_req, force the owner's rdata to 0, set err, go to RESP.
- RESP: owner's ready=1 for exactly one cycle, err as set, m_req=0, then IDLE.
- Stores: d_rdata keeps its previous value.
- Requests are not re-arbitrated during RESP. A req still high in RESP is treated as already served. Requesters drop or change req on the cycle after ready.
- m_ack outside ISSUE (including a late ack after timeout) is ignored.
- grant reflects the owner during ISSUE and RESP, 00 in IDLE.

## Timing
- Reset, asynchronous and immediate: state=IDLE; m_req, m_we, m_wstrb, m_addr, m_wdata, i_rdata, d_rdata, i_ready, d_ready, err, grant all 0; starve_cnt and tmo_cnt = 0. An in-flight memory transaction is abandoned and no ready is produced. Release of rst is synchronous to the next edge.
- Request sampled in IDLE at edge N → m_req=1 from cycle N+1.
- m_ack high in cycle K → ready=1 in cycle K+1 with data → IDLE at K+2.
- Zero-wait memory (ack in the first ISSUE cycle): 3 cycles per transaction, so back-to-back throughput is one transaction per 3 cycles.
- Timeout: m_req is high for exactly TIMEOUT cycles, then RESP with err=1.
- A request arriving during ISSUE or RESP waits; it is arbitrated in the next IDLE cycle.

## Test plan
- Single fetch, i_addr=0x100, m_ack one cycle after m_req, m_rdata=0x00000013 → i_ready pulses 1 cycle, i_rdata=0x00000013, m_we=0, err=0, grant=01.
- Store d_addr=0x2000, d_wdata=0xCAFEBABE, d_wstrb=0xF, zero-wait ack → m_we=1, m_wstrb=F, m_wdata=0xCAFEBABE, d_ready at cycle 3, d_rdata unchanged.
- i_req and d_req held high continuously with STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I…; neither requester starves.
- m_ack never asserted with TIMEOUT=8 → m_req high exactly 8 cycles, then owner ready=1, err=1, rdata=0; a late m_ack afterwards produces no extra ready.
- rst asserted mid-ISSUE → all outputs 0 in the same cycle, no ready pulse; after release, a new fetch completes normally.
